k12a_spi_slave: RTL and testbench
=================================

# k12a_spi_slave

SPI mode-0 responder: the device end of the k12a SPI master port (`spi_sck`/`spi_mosi`/`spi_miso`). It oversamples the master's pins in the `cpu_clock` domain, deserialises MOSI bytes into a parallel receive strobe and serialises a locally supplied byte onto MISO. It is used as an on-board peripheral model and as the bench partner for system tests that exercise the SPI port, with slave-select driven from a k12a GPIO output.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth on `spi_ss_n`, `spi_sck` and `spi_mosi`; legal values are ≥2.
- `DEFAULT_TX`, default 8'hFF: byte shifted out when no byte has been supplied.

- `cpu_clock`  in  1  sole clock; all logic is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `spi_ss_n`  in  1  slave select, active low, asynchronous to `cpu_clock`.
- `spi_sck`  in  1  serial clock from the master, asynchronous; idles low (CPOL=0).
- `spi_mosi`  in  1  master-to-slave data, asynchronous.
- `spi_miso`  out  1  slave-to-master data, registered.
- `rx_data`  out  8  last complete received byte.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` is updated.
- `tx_data`  in  8  next byte to transmit.
- `tx_load`  in  1  strobe that writes `tx_data` into the holding register.
- `tx_ready`  out  1  holding register is empty and can accept `tx_load`.
- `busy`  out  1  synchronised slave select is active.

## Operation
- Reset values: `spi_miso`=1, `rx_data`=0, `rx_valid`=0, `tx_ready`=1, `busy`=0, bit counter=0, state IDLE.
- The block detects edges on the synchronised `spi_sck` and `spi_ss_n` signals (last stage versus a delayed copy).
- States:
  - IDLE: `spi_ss_n` is high. `spi_miso` is held at 1. Edges on `spi_sck` are ignored.
  - IDLE → SHIFT on the `spi_ss_n` falling edge:
    - Load the tx shift register from the byte source (see Configuration).
    - Drive bit 7 of that byte on `spi_miso`.
    - Clear the bit counter.
  - SHIFT, on each `spi_sck` rising edge:
    - `rx_shift` ← {`rx_shift`[6:0], mosi}.
    - The bit counter increments modulo 8.
    - When the counter is 7 before the edge, the next cycle sets `rx_data` to the completed byte and pulses `rx_valid`.
  - SHIFT, on each `spi_sck` falling edge:
    - If the counter is 0 (a byte boundary), load the next byte from the byte source and drive its bit 7.
    - Otherwise shift the tx register left and drive the new bit 7.
  - SHIFT → IDLE on the `spi_ss_n` rising edge, from any bit position:
    - The partial rx byte is discarded and `rx_valid` does not pulse.
    - The partial tx byte is dropped.
    - The counter clears and `spi_miso` returns to 1.
- Transmission is MSB first. Bytes are back-to-back with no gap and no limit on their number.
- A simultaneous `spi_sck` edge and `spi_ss_n` rising edge: deselect wins and the sck edge is ignored.

## Timing
- `spi_sck` pin rise to `rx_valid` pulse: SYNC_STAGES+2 cycles.
- `spi_sck` pin fall to `spi_miso` update: SYNC_STAGES+1 cycles.
- `spi_ss_n` pin fall to first MISO bit valid: SYNC_STAGES+1 cycles.
- Master constraints, in `cpu_clock` cycles:
  - `spi_sck` high time and low time ≥ SYNC_STAGES+3.
  - `spi_ss_n` fall to first `spi_sck` rise ≥ SYNC_STAGES+3.
  - Last `spi_sck` fall to `spi_ss_n` rise ≥ 2.
- Reset mid-transfer returns all outputs to reset values immediately. The transfer is resumed only after `spi_ss_n` is deasserted and reasserted.

## Configuration
- `K12A_SPI_SLAVE_TXBUF_EN` defined:
  - The block has an 8-bit holding register.
  - `tx_load` while `tx_ready`=1 captures `tx_data` and drops `tx_ready` next cycle. `tx_load` while `tx_ready`=0 is ignored.
  - At each byte load, a full holding register moves to the shift register and `tx_ready` rises the next cycle. An empty holding register supplies `DEFAULT_TX`.
  - A `tx_load` in the same cycle as a byte load into an empty holding register is captured for the following byte; the current byte is `DEFAULT_TX`.
- Macro undefined:
  - There is no holding register and the byte source is `tx_data`, sampled directly at each byte load.
  - `tx_load` is ignored and `tx_ready` is tied to 1.

## Structure
- Package `k12a_spi_pkg` contains:
  - `SPI_BYTE_WIDTH`=8.
  - `typedef logic [7:0] spi_byte_t`.
  - The state enum `spi_slave_state_t` {IDLE, SHIFT}.
- Sub-module `k12a_sync`: a parameterised N-stage flop synchroniser with a reset value input. It is instantiated for SS (reset 1), SCK (reset 0) and MOSI (reset 0).

## Test plan
- Load 8'hA5, select, master sends 8'h3C with SCK half-period 8 cycles → master reads 8'hA5, `rx_data`=8'h3C, one `rx_valid` pulse SYNC_STAGES+2 cycles after the 8th SCK rise.
- Three back-to-back bytes 8'h01/8'h02/8'h03, loading 8'h10/8'h20 only → MISO returns 8'h10, 8'h20, 8'hFF; three `rx_valid` pulses.
- Deselect after 5 bits of 8'hFF → no `rx_valid`, MISO=1; the next selected byte 8'h81 is received intact.
- `tx_load` in the exact byte-load cycle with an empty buffer (TXBUF_EN) → 8'hFF is sent now and the loaded byte is sent in the next byte.
- Assert `reset_n` low at bit 4 → all outputs return to reset values; after reselect, 8'h5A is received correctly.
- Build without the macro: `tx_data`=8'hC3 held steady → master reads 8'hC3, `tx_ready` stays 1.

Source files
------------

// File: rtl/k12a_spi_pkg.sv
// Shared types for the k12a SPI mode-0 responder.
package k12a_spi_pkg;

  localparam int SPI_BYTE_WIDTH = 8;

  typedef logic [SPI_BYTE_WIDTH-1:0] spi_byte_t;

  typedef enum logic {
    IDLE,
    SHIFT
  } spi_slave_state_t;

endpackage

// File: rtl/k12a_sync.sv
// N-stage flop synchroniser; rst_val is the level the chain presents out of reset.
module k12a_sync #(
  parameter int STAGES = 2
) (
  input  logic cpu_clock,
  input  logic reset_n,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) ff <= {STAGES{rst_val}};
    else          ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/k12a_spi_slave.sv
// SPI mode-0 responder oversampling the master pins in the cpu_clock domain.
// Define K12A_SPI_SLAVE_TXBUF_EN to add the 8-bit tx holding register.
module k12a_spi_slave
  import k12a_spi_pkg::*;
#(
  parameter int        SYNC_STAGES = 2,
  parameter spi_byte_t DEFAULT_TX  = 8'hFF
) (
  input  logic      cpu_clock,
  input  logic      reset_n,
  input  logic      spi_ss_n,
  input  logic      spi_sck,
  input  logic      spi_mosi,
  output logic      spi_miso,
  output spi_byte_t rx_data,
  output logic      rx_valid,
  input  spi_byte_t tx_data,
  input  logic      tx_load,
  output logic      tx_ready,
  output logic      busy
);

  localparam int NPINS = 3;
  localparam logic [NPINS-1:0] PIN_RST = 3'b001;

  logic [NPINS-1:0] pins, pins_s;
  logic ss_s, sck_s, mosi_s;

  assign pins = {spi_mosi, spi_sck, spi_ss_n};

  for (genvar g = 0; g < NPINS; g++) begin : g_sync
    k12a_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .cpu_clock (cpu_clock),
      .reset_n   (reset_n),
      .rst_val   (PIN_RST[g]),
      .d         (pins[g]),
      .q         (pins_s[g])
    );
  end

  assign {mosi_s, sck_s, ss_s} = pins_s;

  spi_slave_state_t state;
  logic             ss_d, sck_d;
  logic             ss_fall, ss_rise, sck_rise, sck_fall;
  logic             sel_start, byte_load;
  logic [2:0]       bit_cnt;
  spi_byte_t        rx_shift;
  logic [6:0]       tx_rest;
  logic             rx_pend;
  spi_byte_t        byte_src;
  logic [SYNC_STAGES-1:0] warm;
  logic             armed;

  always_comb begin
    ss_fall   = ss_d & ~ss_s;
    ss_rise   = ~ss_d & ss_s;
    sck_rise  = ~sck_d & sck_s;
    sck_fall  = sck_d & ~sck_s;
    sel_start = (state == IDLE) & armed & ss_fall;
    byte_load = sel_start |
                ((state == SHIFT) & ~ss_rise & sck_fall & (bit_cnt == 3'd0));
  end

  // A select already low when reset releases must not start a transfer:
  // wait until the chain is flushed and select has been seen high.
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      warm  <= '0;
      armed <= 1'b0;
      ss_d  <= 1'b1;
      sck_d <= 1'b0;
    end else begin
      warm  <= {warm[SYNC_STAGES-2:0], 1'b1};
      armed <= armed | (warm[SYNC_STAGES-1] & ss_s);
      ss_d  <= ss_s;
      sck_d <= sck_s;
    end
  end

`ifdef K12A_SPI_SLAVE_TXBUF_EN
  spi_byte_t hold;
  logic      hold_full;

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (byte_load && hold_full) begin
      hold_full <= 1'b0;
    end else if (tx_load && !hold_full) begin
      hold      <= tx_data;
      hold_full <= 1'b1;
    end
  end

  assign byte_src = hold_full ? hold : DEFAULT_TX;
  assign tx_ready = ~hold_full;
`else
  logic unused_tx;

  assign unused_tx = ^{tx_load, DEFAULT_TX};
  assign byte_src  = tx_data;
  assign tx_ready  = 1'b1;
`endif

  // spi_miso holds the bit on the wire; tx_rest holds the bits still to go.
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_rest  <= '0;
      spi_miso <= 1'b1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_pend  <= 1'b0;
    end else begin
      rx_valid <= rx_pend;
      rx_pend  <= 1'b0;
      if (rx_pend) rx_data <= rx_shift;
      case (state)
        IDLE: begin
          spi_miso <= 1'b1;
          bit_cnt  <= '0;
          if (sel_start) begin
            state    <= SHIFT;
            tx_rest  <= byte_src[6:0];
            spi_miso <= byte_src[7];
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            rx_shift <= '0;
            spi_miso <= 1'b1;
          end else if (sck_rise) begin
            rx_shift <= {rx_shift[6:0], mosi_s};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) rx_pend <= 1'b1;
          end else if (sck_fall) begin
            if (bit_cnt == 3'd0) begin
              tx_rest  <= byte_src[6:0];
              spi_miso <= byte_src[7];
            end else begin
              tx_rest  <= {tx_rest[5:0], 1'b0};
              spi_miso <= tx_rest[6];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_k12a_spi_slave.sv
// Directed bench for k12a_spi_slave; covers both K12A_SPI_SLAVE_TXBUF_EN builds.
module tb_k12a_spi_slave;

  localparam int SYNC = 2;
  localparam int H    = 8;
`ifdef K12A_SPI_SLAVE_TXBUF_EN
  localparam bit TXBUF = 1'b1;
`else
  localparam bit TXBUF = 1'b0;
`endif

  logic       cpu_clock, reset_n;
  logic       spi_ss_n, spi_sck, spi_mosi, spi_miso;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, tx_load, tx_ready, busy;

  k12a_spi_slave #(.SYNC_STAGES(SYNC), .DEFAULT_TX(8'hFF)) dut (
    .cpu_clock (cpu_clock),
    .reset_n   (reset_n),
    .spi_ss_n  (spi_ss_n),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .tx_ready  (tx_ready),
    .busy      (busy)
  );

  initial cpu_clock = 1'b0;
  always #5 cpu_clock = ~cpu_clock;

  int total = 0, bad = 0;
  int cyc = 0, last_rise = 0, rx_cyc = 0, rx_pulses = 0;
  logic [7:0] rx_last = 8'h00;

  always @(posedge cpu_clock) cyc <= cyc + 1;

  always @(negedge cpu_clock) begin
    if (rx_valid === 1'b1) begin
      rx_pulses = rx_pulses + 1;
      rx_last   = rx_data;
      rx_cyc    = cyc;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge cpu_clock);
  endtask

  task automatic give(input logic [7:0] b);
    tx_data = b;
    tx_load = 1'b1;
    wait_cyc(1);
    tx_load = 1'b0;
  endtask

  // Byte source when nothing is supplied: empty buffer, or the idle pattern on tx_data.
  task automatic give_none;
    if (!TXBUF) tx_data = 8'hFF;
  endtask

  task automatic select;
    spi_ss_n = 1'b0;
    wait_cyc(H);
  endtask

  task automatic deselect;
    spi_ss_n = 1'b1;
    wait_cyc(H);
  endtask

  // Master side of one (possibly partial) byte; nxt >= 0 supplies the next byte.
  task automatic xfer(input logic [7:0] mo, input int nbits, input int nxt,
                      output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[7-i];
      wait_cyc(H);
      spi_sck   = 1'b1;
      mi        = {mi[6:0], spi_miso};
      last_rise = cyc;
      if (i == 7) begin
        if (nxt >= 0) give(8'(nxt));
        else          give_none();
      end
      wait_cyc(H);
      spi_sck = 1'b0;
    end
    wait_cyc(H);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; spi_ss_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    tx_data = 8'h00; tx_load = 1'b0;
    wait_cyc(3);
    total++; if (spi_miso !== 1'b1) begin bad++; $display("FAIL rst_miso got=%b want=1", spi_miso); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rst_rx_valid got=%b want=0", rx_valid); end
    reset_n = 1'b1;
    wait_cyc(6);
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_rx_data got=%h want=00", rx_data); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rst_tx_ready got=%b want=1", tx_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
  endtask

  task automatic test_basic;
    logic [7:0] mi;
    int p0;
    p0 = rx_pulses;
    give(8'hA5);
    total++; if (tx_ready !== !TXBUF) begin bad++; $display("FAIL basic_ready_loaded got=%b want=%b", tx_ready, !TXBUF); end
    select();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_moved got=%b want=1", tx_ready); end
    xfer(8'h3C, 8, -1, mi);
    deselect();
    total++; if (mi !== 8'hA5) begin bad++; $display("FAIL basic_miso got=%h want=a5", mi); end
    total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL basic_rx_data got=%h want=3c", rx_data); end
    total++; if (rx_pulses - p0 !== 1) begin bad++; $display("FAIL basic_pulses got=%0d want=1", rx_pulses - p0); end
    total++; if (rx_cyc - last_rise !== SYNC + 2) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", rx_cyc - last_rise, SYNC + 2); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] m0, m1, m2;
    int p0;
    p0 = rx_pulses;
    give(8'h10);
    select();
    xfer(8'h01, 8, 'h20, m0);
    xfer(8'h02, 8, -1, m1);
    xfer(8'h03, 8, -1, m2);
    deselect();
    total++; if (m0 !== 8'h10) begin bad++; $display("FAIL b2b_miso0 got=%h want=10", m0); end
    total++; if (m1 !== 8'h20) begin bad++; $display("FAIL b2b_miso1 got=%h want=20", m1); end
    total++; if (m2 !== 8'hFF) begin bad++; $display("FAIL b2b_miso2 got=%h want=ff", m2); end
    total++; if (rx_pulses - p0 !== 3) begin bad++; $display("FAIL b2b_pulses got=%0d want=3", rx_pulses - p0); end
    total++; if (rx_last !== 8'h03) begin bad++; $display("FAIL b2b_rx_last got=%h want=03", rx_last); end
  endtask

  task automatic test_deselect;
    logic [7:0] mi;
    int p0;
    p0 = rx_pulses;
    give_none();
    select();
    xfer(8'hFF, 5, -1, mi);
    deselect();
    total++; if (rx_pulses !== p0) begin bad++; $display("FAIL dsel_pulses got=%0d want=%0d", rx_pulses, p0); end
    total++; if (spi_miso !== 1'b1) begin bad++; $display("FAIL dsel_miso got=%b want=1", spi_miso); end
    give(8'h42);
    select();
    xfer(8'h81, 8, -1, mi);
    deselect();
    total++; if (rx_last !== 8'h81) begin bad++; $display("FAIL dsel_next_rx got=%h want=81", rx_last); end
    total++; if (rx_pulses - p0 !== 1) begin bad++; $display("FAIL dsel_next_pulses got=%0d want=1", rx_pulses - p0); end
    total++; if (mi !== 8'h42) begin bad++; $display("FAIL dsel_next_miso got=%h want=42", mi); end
  endtask

`ifdef K12A_SPI_SLAVE_TXBUF_EN
  task automatic test_load_collide;
    logic [7:0] m0, m1;
    spi_ss_n = 1'b0;
    wait_cyc(2);
    tx_data = 8'h77;
    tx_load = 1'b1;
    wait_cyc(1);
    tx_load = 1'b0;
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL collide_ready got=%b want=0", tx_ready); end
    wait_cyc(6);
    xfer(8'h11, 8, -1, m0);
    xfer(8'h22, 8, -1, m1);
    deselect();
    total++; if (m0 !== 8'hFF) begin bad++; $display("FAIL collide_miso0 got=%h want=ff", m0); end
    total++; if (m1 !== 8'h77) begin bad++; $display("FAIL collide_miso1 got=%h want=77", m1); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL collide_ready_end got=%b want=1", tx_ready); end
  endtask
`else
  task automatic test_passthrough;
    logic [7:0] m0, m1;
    tx_data = 8'hC3;
    select();
    xfer(8'h00, 8, 'hC3, m0);
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL pass_ready got=%b want=1", tx_ready); end
    xfer(8'h00, 8, 'hC3, m1);
    deselect();
    total++; if (m0 !== 8'hC3) begin bad++; $display("FAIL pass_miso0 got=%h want=c3", m0); end
    total++; if (m1 !== 8'hC3) begin bad++; $display("FAIL pass_miso1 got=%h want=c3", m1); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL pass_ready_end got=%b want=1", tx_ready); end
  endtask
`endif

  task automatic test_reset_mid;
    logic [7:0] mi;
    int p0;
    p0 = rx_pulses;
    give(8'hE7);
    select();
    xfer(8'h5A, 4, -1, mi);
    reset_n = 1'b0;
    #1;
    total++; if (spi_miso !== 1'b1) begin bad++; $display("FAIL rmid_miso got=%b want=1", spi_miso); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rmid_rx_data got=%h want=00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rmid_rx_valid got=%b want=0", rx_valid); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rmid_tx_ready got=%b want=1", tx_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(4);
    // select still low: clocks must be ignored until a fresh select
    for (int i = 0; i < 3; i++) begin
      spi_sck = 1'b1; wait_cyc(H);
      spi_sck = 1'b0; wait_cyc(H);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy_held got=%b want=0", busy); end
    total++; if (spi_miso !== 1'b1) begin bad++; $display("FAIL rmid_miso_held got=%b want=1", spi_miso); end
    total++; if (rx_pulses !== p0) begin bad++; $display("FAIL rmid_pulses got=%0d want=%0d", rx_pulses, p0); end
    deselect();
    give(8'h96);
    select();
    xfer(8'h5A, 8, -1, mi);
    deselect();
    total++; if (rx_data !== 8'h5A) begin bad++; $display("FAIL rmid_rx_after got=%h want=5a", rx_data); end
    total++; if (mi !== 8'h96) begin bad++; $display("FAIL rmid_miso_after got=%h want=96", mi); end
    total++; if (rx_pulses - p0 !== 1) begin bad++; $display("FAIL rmid_pulses_after got=%0d want=1", rx_pulses - p0); end
  endtask

  initial begin
    @(negedge cpu_clock);
    test_reset();
    test_basic();
    test_back_to_back();
    test_deselect();
`ifdef K12A_SPI_SLAVE_TXBUF_EN
    test_load_collide();
`else
    test_passthrough();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
